load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Core-side and memory-side signals of the load/store unit.
// The slave modport is the LSU's view; the master modport drives the core and memory inputs.
interface load_store_unit_if;
  logic        memread;
  logic        memwrite;
  logic [1:0]  size;
  logic        signext;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        stall;
  logic        misaligned;
  logic        buserror;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  memread, memwrite, size, signext, addr, writedata, mem_rdata, mem_ack,
    output readdata, stall, misaligned, buserror, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output memread, memwrite, size, signext, addr, writedata, mem_rdata, mem_ack,
    input  readdata, stall, misaligned, buserror, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: aligns core accesses onto a word bus with byte enables,
// extracts and extends load data, and flags alignment and timeout faults.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cnt;
  logic        r_we;
  logic [29:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_size;
  logic [1:0]  r_off;
  logic        r_signext;

  logic        w_access;
  logic        w_aligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_access = bus.memread | bus.memwrite;

  // Store lane encoding and alignment decode for the request presented this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = '0;
    case (bus.size)
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << bus.addr[1:0];
        w_wdata   = {4{bus.writedata[7:0]}};
      end
      2'b01: begin
        w_aligned = ~bus.addr[0];
        w_be      = bus.addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{bus.writedata[15:0]}};
      end
      2'b10: begin
        w_aligned = (bus.addr[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = bus.writedata;
      end
      default: ;
    endcase
    if (!bus.memwrite) w_wdata = '0;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_access && w_aligned) w_next = S_REQ;
      S_REQ: begin
        if (bus.mem_ack)             w_next = S_DONE;
        else if (r_cnt == CNT_LAST)  w_next = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_size    <= '0;
      r_off     <= '0;
      r_signext <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_REQ) begin
        r_we      <= bus.memwrite;
        r_addr    <= bus.addr[31:2];
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_cnt     <= '0;
        r_size    <= bus.size;
        r_off     <= bus.addr[1:0];
        r_signext <= bus.signext;
      end else if (r_state == S_REQ) begin
        if (bus.mem_ack) r_rdata <= bus.mem_rdata;
        else             r_cnt   <= r_cnt + 8'd1;
      end
    end
  end

  // Load extraction from the captured word; only the DONE state exposes it.
  always_comb begin
    w_shifted = r_rdata >> {r_off, 3'b000};
    w_half    = r_off[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_size)
      2'b00:   w_load = {{24{r_signext & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{r_signext & w_half[15]}}, w_half};
      default: w_load = r_rdata;
    endcase
  end

  // Reset masks the combinational IDLE outputs so nothing asserts until release.
  assign bus.stall      = ~reset & (((r_state == S_IDLE) & w_access & w_aligned) | (r_state == S_REQ));
  assign bus.misaligned = ~reset & (r_state == S_IDLE) & w_access & ~w_aligned;
  assign bus.buserror   = (r_state == S_ERR);
  assign bus.mem_req    = (r_state == S_REQ);
  assign bus.mem_we     = r_we;
  assign bus.mem_addr   = r_addr;
  assign bus.mem_be     = r_be;
  assign bus.mem_wdata  = r_wdata;
  assign bus.readdata   = (r_state == S_DONE && !r_we) ? w_load : 32'h0;

endmodule
